// File: rtl/instr_queue.sv
// Fetch-to-decode instruction FIFO with flush and a full/empty count.
// Define INSTR_QUEUE_BYPASS_EN to let an empty queue forward in_instr straight to out_instr.
module instr_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in_instr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  output logic [WIDTH-1:0]         out_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             empty;
  logic             push;
  logic             pop;

  assign empty    = (cnt == '0);
  assign in_ready = (cnt != FULL);
  assign count    = cnt;

`ifdef INSTR_QUEUE_BYPASS_EN
  logic byp;
  logic byp_take;

  // Bypass only ever fires on an empty queue, so it never reorders stored entries.
  assign byp      = empty && in_valid && !flush && !reset;
  assign byp_take = byp && out_ready;
  assign out_valid = !empty || byp;
  assign push = in_valid && in_ready && !flush && !byp_take;
  assign pop  = !empty && out_ready && !flush;

  always_comb begin
    out_instr = '0;
    unique case (1'b1)
      !empty:  out_instr = mem[rd_ptr];
      byp:     out_instr = in_instr;
      default: out_instr = '0;
    endcase
  end
`else
  assign out_valid = !empty;
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    out_instr = '0;
    if (out_valid)
      out_instr = mem[rd_ptr];
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is deliberately left out of reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= in_instr;
  end

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue: ordering, full/empty limits, flush, async reset.
// Build with INSTR_QUEUE_BYPASS_EN to exercise the bypass expectations.
module tb_instr_queue;

  logic       clk;
  logic       reset;
  logic [7:0] in_instr;
  logic       in_valid;
  logic       in_ready;
  logic       flush;
  logic [7:0] out_instr;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] count;

  int n_assert;
  int n_fail;

  instr_queue #(.DEPTH(4), .WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_instr  (in_instr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_instr (out_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] seq [4];
    n_assert  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    in_instr  = 8'h00;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #2;
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_instr", 32'(out_instr), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    reset = 1'b0;

    // fill with four, then drain in order
    seq[0] = 8'h1B; seq[1] = 8'h62; seq[2] = 8'hA7; seq[3] = 8'hFC;
    tick();
    in_valid = 1'b1;
    in_instr = seq[0];
    tick();
    #1;
    chk("lat_out_valid", 32'(out_valid), 1);
    chk("lat_out_instr", 32'(out_instr), 32'h1B);
    chk("lat_count", 32'(count), 1);
    for (int i = 1; i < 4; i++) begin
      in_instr = seq[i];
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("full_count", 32'(count), 4);
    chk("full_in_ready", 32'(in_ready), 0);

    in_valid = 1'b1;
    in_instr = 8'hEE;
    tick();
    in_valid = 1'b0;
    #1;
    chk("blocked_count", 32'(count), 4);
    chk("blocked_head", 32'(out_instr), 32'h1B);

    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_valid", 32'(out_valid), 1);
      chk("drain_instr", 32'(out_instr), 32'(seq[i]));
      tick();
    end
    #1;
    chk("drained_valid", 32'(out_valid), 0);
    chk("drained_count", 32'(count), 0);
    chk("drained_instr", 32'(out_instr), 0);
    out_ready = 1'b0;

    // full queue rejects a push even with a same-cycle pop
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_instr = 8'h41 + 8'(i);
      tick();
    end
    in_instr  = 8'h33;
    out_ready = 1'b1;
    #1;
    chk("nopt_in_ready", 32'(in_ready), 0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("nopt_count", 32'(count), 3);
    for (int i = 0; i < 3; i++) begin
      chk("nopt_drain", 32'(out_instr), 32'h42 + 32'(i));
      tick();
    end
    chk("nopt_empty", 32'(out_valid), 0);
    out_ready = 1'b0;

    // steady push/pop at count 2 across several wraps
    in_valid = 1'b1;
    in_instr = 8'h00;
    tick();
    in_instr = 8'h01;
    tick();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_instr = 8'(k + 2);
      #1;
      chk("stream_count", 32'(count), 2);
      chk("stream_instr", 32'(out_instr), 32'(k));
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("stream_tail0", 32'(out_instr), 32'h08);
    tick();
    chk("stream_tail1", 32'(out_instr), 32'h09);
    tick();
    chk("stream_empty", 32'(out_valid), 0);
    out_ready = 1'b0;

    // flush with a pending push and pop
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_instr = 8'hA1 + 8'(i);
      tick();
    end
    in_instr  = 8'h55;
    flush     = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("flush_pre_ready", 32'(in_ready), 1);
    chk("flush_pre_valid", 32'(out_valid), 1);
    chk("flush_pre_head", 32'(out_instr), 32'hA1);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush_count", 32'(count), 0);
    chk("flush_valid", 32'(out_valid), 0);
    tick();
    chk("flush_no55", 32'(out_valid), 0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 8'h66;
    tick();
    in_valid = 1'b0;
    #1;
    chk("flush_repush", 32'(out_instr), 32'h66);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // asynchronous reset between edges
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_instr = 8'hB1 + 8'(i);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("arst_pre_count", 32'(count), 3);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_instr", 32'(out_instr), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b1;
    in_instr = 8'hC7;
    tick();
    in_valid = 1'b0;
    #1;
    chk("arst_first_push", 32'(out_instr), 32'hC7);
    chk("arst_first_count", 32'(count), 1);
    out_ready = 1'b1;
    tick();
    chk("arst_popped", 32'(count), 0);

    // empty queue with a same-cycle producer and consumer
    in_valid = 1'b1;
    in_instr = 8'h9E;
    #1;
`ifdef INSTR_QUEUE_BYPASS_EN
    chk("byp_valid", 32'(out_valid), 1);
    chk("byp_instr", 32'(out_instr), 32'h9E);
    tick();
    in_valid = 1'b0;
    #1;
    chk("byp_count", 32'(count), 0);
    chk("byp_after", 32'(out_valid), 0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 8'h5A;
    #1;
    chk("byp_hold_instr", 32'(out_instr), 32'h5A);
    tick();
    in_valid = 1'b0;
    #1;
    chk("byp_hold_count", 32'(count), 1);
    chk("byp_hold_head", 32'(out_instr), 32'h5A);
`else
    chk("nobyp_valid", 32'(out_valid), 0);
    chk("nobyp_instr", 32'(out_instr), 0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("nobyp_late_valid", 32'(out_valid), 1);
    chk("nobyp_late_instr", 32'(out_instr), 32'h9E);
    chk("nobyp_late_count", 32'(count), 1);
    tick();
    chk("nobyp_done", 32'(count), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
